// File: rtl/debug_unit_pkg.sv
// Shared definitions for the UART debug unit.
//   - command byte constants
//   - command FSM state type and encodings
//   - snapshot size
//   - baud divisor helper (16x oversampling tick)
// The continuous run/pause feature is built in only when DEBUG_CONTINUOUS_EN is defined.
// When it is not defined, CMD_RUN and CMD_PAUSE are ordinary bytes and ST_RUN is never entered.
`timescale 1ns/1ps
package debug_unit_pkg;

    localparam logic [7:0] CMD_STEP  = 8'h73;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [7:0] CMD_RUN   = 8'h63;
    localparam logic [7:0] CMD_PAUSE = 8'h70;

    localparam int SNAP_BYTES = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_STEP    = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_SEND    = 3'd3;
    localparam state_t ST_WAIT_TX = 3'd4;
    localparam state_t ST_RUN     = 3'd5;

    // Clocks per 16x oversampling tick. Uses floor division, with a minimum of 1.
    function automatic int baud_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * 16);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/debug_uart.sv
// 8N1 UART for the debug unit: tick generator, receiver and transmitter, all LSB first.
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   rx              serial input, idle high
//   rx_data         last correctly framed byte
//   rx_valid        one-cycle strobe for a new rx_data
//   tx_data         byte to send
//   tx_start        request to send; accepted only while tx_busy is low
//   tx_busy         frame in progress; drops during the final stop-bit tick
//   tx              serial output, idle high
`timescale 1ns/1ps
module debug_uart
    import debug_unit_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV - 1);

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_STOP      = 3'd3;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

    logic [DW-1:0] div_cnt;
    logic          tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 div_cnt <= '0;
        else if (div_cnt == '0)  div_cnt <= DIV_RELOAD;
        else                     div_cnt <= div_cnt - 1'b1;
    end

    assign tick = (div_cnt == '0);

    // ---------------- receiver ----------------
    logic [1:0] rx_sync;
    logic       rx_s;
    logic       rx_armed;
    logic [2:0] rx_state;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;

    assign rx_s = rx_sync[1];

    // The synchronizer resets low, so a line held low since reset never arms the receiver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b00;
            rx_armed <= 1'b0;
            rx_state <= RX_IDLE;
            rx_tcnt  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_valid <= 1'b0;
            if (rx_s) rx_armed <= 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_armed && !rx_s) begin
                        rx_state <= RX_START;
                        rx_tcnt  <= 4'd7;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tcnt != 4'd0) begin
                            rx_tcnt <= rx_tcnt - 4'd1;
                        end else if (rx_s) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_tcnt  <= 4'd15;
                            rx_bit   <= 3'd7;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_tcnt != 4'd0) begin
                            rx_tcnt <= rx_tcnt - 4'd1;
                        end else begin
                            rx_shift <= {rx_s, rx_shift[7:1]};
                            rx_tcnt  <= 4'd15;
                            if (rx_bit == 3'd0) rx_state <= RX_STOP;
                            else                rx_bit   <= rx_bit - 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_tcnt != 4'd0) begin
                            rx_tcnt <= rx_tcnt - 4'd1;
                        end else if (rx_s) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    logic       tx_active;
    logic [8:0] tx_shift;
    logic [3:0] tx_bit;
    logic [3:0] tx_tcnt;
    logic       bit_end;
    logic       tx_accept;

    assign bit_end = tick && (tx_tcnt == 4'd0);
    // Busy drops in the final stop-bit tick, so a queued start is accepted in that cycle.
    // This places the next start bit directly after the stop bit.
    assign tx_busy   = tx_active && !(bit_end && (tx_bit == 4'd0));
    assign tx_accept = tx_start && !tx_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx        <= 1'b1;
            tx_active <= 1'b0;
            tx_shift  <= 9'd0;
            tx_bit    <= 4'd0;
            tx_tcnt   <= 4'd0;
        end else if (tx_accept) begin
            tx        <= 1'b0;
            tx_shift  <= {1'b1, tx_data};
            tx_bit    <= 4'd9;
            tx_tcnt   <= 4'd15;
            tx_active <= 1'b1;
        end else if (tx_active && bit_end) begin
            tx_tcnt <= 4'd15;
            if (tx_bit == 4'd0) begin
                tx_active <= 1'b0;
                tx        <= 1'b1;
            end else begin
                tx       <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bit   <= tx_bit - 4'd1;
            end
        end else if (tx_active && tick) begin
            tx_tcnt <= tx_tcnt - 4'd1;
        end
    end

endmodule

// File: rtl/debug_unit.sv
// UART debug unit for the pipelined processor.
// It decodes single-byte commands, pulses the pipeline step enable, snapshots PC and R0,
// and returns the 8-byte snapshot over tx.
// Ports:
//   clk                system clock
//   btn                asynchronous active-high reset
//   rx / tx            UART pins (8N1, LSB first)
//   inRegistro0, inPc  pipeline observation inputs
//   rx_data_out_debug  last correctly framed received byte
//   outStep            pipeline step enable
// Optional feature: DEBUG_CONTINUOUS_EN adds RUN ('c' starts, 'p' pauses and then dumps).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command byte
// STEP     | outStep high for this single cycle
// CAPTURE  | latch PC and R0 into the snapshot
// SEND     | start transmitting snapshot byte 0
// WAIT_TX  | queue bytes 1..7 back-to-back, then return to IDLE
// RUN      | outStep held high until CMD_PAUSE (DEBUG_CONTINUOUS_EN only)
`timescale 1ns/1ps
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
)(
    input  logic        clk,
    input  logic        btn,
    input  logic        rx,
    input  logic [31:0] inRegistro0,
    input  logic [31:0] inPc,
    output logic [7:0]  rx_data_out_debug,
    output logic        tx,
    output logic        outStep
);

    state_t                     state;
    logic [3:0]                 byte_idx;
    logic [8*SNAP_BYTES-1:0]    snap;
    logic [7:0]                 rx_data;
    logic                       rx_valid;
    logic [7:0]                 tx_data;
    logic                       tx_start;
    logic                       tx_busy;

    debug_uart #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart (
        .clk      (clk),
        .rst      (btn),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx       (tx)
    );

    assign rx_data_out_debug = rx_data;
    assign outStep = (state == ST_STEP) || (state == ST_RUN);

    always_comb begin
        tx_start = 1'b0;
        tx_data  = snap[{byte_idx[2:0], 3'b000} +: 8];
        case (state)
            ST_SEND:    tx_start = 1'b1;
            ST_WAIT_TX: tx_start = (byte_idx != 4'(SNAP_BYTES));
            default:    tx_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge btn) begin
        if (btn) begin
            state    <= ST_IDLE;
            byte_idx <= 4'd0;
            snap     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_STEP)      state <= ST_STEP;
                        else if (rx_data == CMD_DUMP) state <= ST_CAPTURE;
`ifdef DEBUG_CONTINUOUS_EN
                        else if (rx_data == CMD_RUN)  state <= ST_RUN;
`endif
                    end
                end
                ST_STEP: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    // Byte 0 is PC[7:0]; R0 follows PC, both least-significant byte first.
                    snap     <= {inRegistro0, inPc};
                    byte_idx <= 4'd0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        byte_idx <= 4'd1;
                        state    <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (!tx_busy) begin
                        if (byte_idx == 4'(SNAP_BYTES)) state    <= ST_IDLE;
                        else                            byte_idx <= byte_idx + 4'd1;
                    end
                end
`ifdef DEBUG_CONTINUOUS_EN
                ST_RUN: begin
                    if (rx_valid && (rx_data == CMD_PAUSE)) state <= ST_CAPTURE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
`timescale 1ns/1ps
module tb_debug_unit;

    localparam int CLK_HZ  = 6_400_000;
    localparam int BAUD    = 100_000;
    localparam int TICK    = CLK_HZ / (BAUD * 16);
    localparam int BIT     = TICK * 16;
    localparam int BYTE    = BIT * 10;
    localparam int DUMP_TO = BYTE * 11;

    logic        clk = 1'b0;
    logic        btn;
    logic        rx;
    logic [31:0] inRegistro0;
    logic [31:0] inPc;
    logic [7:0]  rx_data_out_debug;
    logic        tx;
    logic        outStep;

    int n_checks = 0;
    int n_errors = 0;

    debug_unit #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk               (clk),
        .btn               (btn),
        .rx                (rx),
        .inRegistro0       (inRegistro0),
        .inPc              (inPc),
        .rx_data_out_debug (rx_data_out_debug),
        .tx                (tx),
        .outStep           (outStep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle bookkeeping, sampled at the falling edge.
    int   cyc = 0, valid_cnt = 0, valid_cyc = -1, step_cnt = 0, rise_cyc = -1, fall_cyc = -1;
    logic prev_step = 1'b0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_step <= outStep;
        if (dut.rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (outStep) step_cnt <= step_cnt + 1;
        if (outStep && !prev_step) rise_cyc <= cyc;
        if (!outStep && prev_step) fall_cyc <= cyc;
    end

    // Serial monitor on tx. It collects bytes and the cycle on which each start bit began.
    logic [7:0] got_q[$];
    int         start_q[$];
    int         frame_err = 0;

    initial begin
        forever begin
            logic [7:0] b;
            int st;
            @(negedge tx);
            st = cyc;
            repeat (BIT / 2) @(negedge clk);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                got_q.push_back(b);
                start_q.push_back(st);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    // Reference: the dump is PC then R0, each least-significant byte first, sent back-to-back.
    task automatic expect_dump(input string tag, input logic [31:0] pc, input logic [31:0] r0);
        logic [7:0] exp_q[$];
        int t;
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((pc >> (8 * i)) & 32'hFF));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((r0 >> (8 * i)) & 32'hFF));
        t = 0;
        while (got_q.size() < 8 && t < DUMP_TO) begin
            @(negedge clk);
            t++;
        end
        repeat (BIT) @(negedge clk);
        check({tag, "_nbytes"}, 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < got_q.size())
                check($sformatf("%s_b%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        if (start_q.size() >= 8)
            check({tag, "_b2b"}, 64'(start_q[7] - start_q[1]), 64'(6 * BYTE));
        got_q.delete();
        start_q.delete();
    endtask

    task automatic quiet(input string tag);
        repeat (2 * BIT) @(negedge clk);
        check({tag, "_no_tx"}, 64'(got_q.size()), 64'd0);
    endtask

    initial begin
        int vc, sc, cv;
        logic [31:0] pc, r0;
        logic [7:0]  cmd;
        int kind;

        btn = 1'b1;
        rx = 1'b0;
        inPc = 32'h0;
        inRegistro0 = 32'h0;
        #1;
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_step", 64'(outStep), 64'd0);
        repeat (10) @(negedge clk);
        btn = 1'b0;
        #1000;
        check("lowline_no_valid", 64'(valid_cnt), 64'd0);
        check("lowline_rxdata", 64'(rx_data_out_debug), 64'h00);
        check("lowline_tx", 64'(tx), 64'd1);
        check("lowline_step", 64'(outStep), 64'd0);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("armed_no_valid", 64'(valid_cnt), 64'd0);

        // A short low pulse is rejected as a glitch at the mid-start-bit check.
        rx = 1'b0;
        repeat (3 * TICK) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_no_valid", 64'(valid_cnt), 64'd0);

        // Step command
        inPc = 32'h0;
        inRegistro0 = 32'h05EBD7AF;
        vc = valid_cnt;
        sc = step_cnt;
        send_byte(8'h73, 1'b1);
        check("step_rxdata", 64'(rx_data_out_debug), 64'h73);
        check("step_valid", 64'(valid_cnt), 64'(vc + 1));
        check("step_width", 64'(step_cnt), 64'(sc + 1));
        check("step_rise", 64'(rise_cyc), 64'(valid_cyc + 1));
        check("step_fall", 64'(fall_cyc), 64'(rise_cyc + 1));
        expect_dump("step_dump", 32'h0, 32'h05EBD7AF);

        // Dump command
        inPc = 32'h00000040;
        sc = step_cnt;
        send_byte(8'h64, 1'b1);
        check("dump_rxdata", 64'(rx_data_out_debug), 64'h64);
        check("dump_no_step", 64'(step_cnt), 64'(sc));
        expect_dump("dump", 32'h00000040, 32'h05EBD7AF);

        // A framing error discards the byte.
        vc = valid_cnt;
        send_byte(8'h41, 1'b0);
        check("ferr_rxdata", 64'(rx_data_out_debug), 64'h64);
        check("ferr_valid", 64'(valid_cnt), 64'(vc));
        check("ferr_no_step", 64'(step_cnt), 64'(sc));
        quiet("ferr");

        // A step sent during a dump is ignored, and the snapshot holds across input changes.
        pc = $urandom;
        r0 = $urandom;
        inPc = pc;
        inRegistro0 = r0;
        sc = step_cnt;
        vc = valid_cnt;
        send_byte(8'h64, 1'b1);
        inPc = ~pc;
        inRegistro0 = ~r0;
        send_byte(8'h73, 1'b1);
        check("busy_rxdata", 64'(rx_data_out_debug), 64'h73);
        check("busy_valid", 64'(valid_cnt), 64'(vc + 2));
        check("busy_no_step", 64'(step_cnt), 64'(sc));
        expect_dump("busy_dump", pc, r0);

        // Reset in the middle of a dump
        send_byte(8'h64, 1'b1);
        repeat (3 * BIT) @(negedge clk);
        btn = 1'b1;
        #1;
        check("abort_tx", 64'(tx), 64'd1);
        check("abort_step", 64'(outStep), 64'd0);
        check("abort_rxdata", 64'(rx_data_out_debug), 64'h00);
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        got_q.delete();
        start_q.delete();
        frame_err = 0;

        // Random commands checked against the command rules.
        for (int n = 0; n < 4; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                cmd = 8'h73;
            end else if (kind == 1) begin
                cmd = 8'h64;
            end else begin
                cmd = 8'($urandom_range(0, 255));
                while (cmd == 8'h73 || cmd == 8'h64 || cmd == 8'h63 || cmd == 8'h70)
                    cmd = 8'($urandom_range(0, 255));
            end
            pc = $urandom;
            r0 = $urandom;
            inPc = pc;
            inRegistro0 = r0;
            sc = step_cnt;
            send_byte(cmd, 1'b1);
            check($sformatf("rnd%0d_rxdata", n), 64'(rx_data_out_debug), 64'(cmd));
            check($sformatf("rnd%0d_step", n), 64'(step_cnt), 64'(sc + ((cmd == 8'h73) ? 1 : 0)));
            if (kind != 2) expect_dump($sformatf("rnd%0d", n), pc, r0);
            else           quiet($sformatf("rnd%0d", n));
        end

`ifdef DEBUG_CONTINUOUS_EN
        pc = $urandom;
        r0 = $urandom;
        inPc = pc;
        inRegistro0 = r0;
        sc = step_cnt;
        send_byte(8'h63, 1'b1);
        cv = valid_cyc;
        check("run_high", 64'(outStep), 64'd1);
        check("run_rise", 64'(rise_cyc), 64'(cv + 1));
        send_byte(8'h73, 1'b1);
        check("run_ignore", 64'(outStep), 64'd1);
        check("run_no_tx", 64'(got_q.size()), 64'd0);
        send_byte(8'h70, 1'b1);
        check("pause_fall", 64'(fall_cyc), 64'(valid_cyc + 1));
        check("run_width", 64'(step_cnt - sc), 64'(valid_cyc - cv));
        expect_dump("pause_dump", pc, r0);
`else
        sc = step_cnt;
        send_byte(8'h63, 1'b1);
        check("c_ignored_step", 64'(step_cnt), 64'(sc));
        check("c_ignored_low", 64'(outStep), 64'd0);
        quiet("c_ignored");
`endif

        check("frame_err", 64'(frame_err), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
